// File: rtl/seller_pkg.sv
// seller_pkg: shared key indices and vector types
// for the seller front end and the sellersm bench.
package seller_pkg;

  localparam int NUM_KEYS = 6;

  // Key indices, highest priority first.
  localparam int KEY_CANCEL = 0;
  localparam int KEY_START  = 1;
  localparam int KEY_RMB10  = 2;
  localparam int KEY_RMB1   = 3;
  localparam int KEY_SEL25  = 4;
  localparam int KEY_SEL5   = 5;

  typedef logic [NUM_KEYS-1:0] key_vec_t;

  // Isolates the lowest set bit, which is the
  // highest-priority request in this bit order.
  function automatic key_vec_t first_set(
    input key_vec_t v
  );
    return v & (~v + key_vec_t'(1));
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: one raw button to a clean press edge.
// Synchroniser, stability counter, rise detect.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES+1)
) (
  input  logic cp,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser for the asynchronous level.
  always_ff @(posedge cp) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Accept a new level only after it has disagreed
  // with the current one for a full run of cycles.
  always_ff @(posedge cp) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (s2 == stable) begin
      cnt    <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= s2;
      cnt    <= '0;
    end else begin
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Delayed copy of the accepted level for edge detect.
  always_ff @(posedge cp) begin
    if (rst) begin
      stable_d <= 1'b0;
    end else begin
      stable_d <= stable;
    end
  end

  // Press edge only; a release produces nothing.
  assign rise = stable & ~stable_d;

endmodule

// File: rtl/seller_key_cond.sv
// seller_key_cond: six debounced keys, priority
// arbitrated into one command pulse per clock.
module seller_key_cond
  import seller_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES+1)
) (
  input  logic     cp,
  input  logic     rst,
  input  key_vec_t key_raw,
  output logic     start,
  output logic     rmb1,
  output logic     rmb10,
  output logic     sel25,
  output logic     sel5,
  output logic     cancel_n,
  output key_vec_t pending
);

  key_vec_t rise;
  key_vec_t req;
  key_vec_t grant;
  key_vec_t pend_q;
  key_vec_t pend_d;
  key_vec_t cmd_q;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .cp   (cp),
      .rst  (rst),
      .raw  (key_raw[i]),
      .rise (rise[i])
    );
  end

  // A fresh rise competes in the same cycle, so an
  // uncontested press is issued without waiting.
  always_comb begin
    req    = pend_q | rise;
    grant  = first_set(req);
    pend_d = req & ~grant;
  end

  // Pending set and one-hot command register.
  always_ff @(posedge cp) begin
    if (rst) begin
      pend_q <= '0;
      cmd_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cmd_q  <= grant;
    end
  end

  assign cancel_n = ~cmd_q[KEY_CANCEL];
  assign start    = cmd_q[KEY_START];
  assign rmb10    = cmd_q[KEY_RMB10];
  assign rmb1     = cmd_q[KEY_RMB1];
  assign sel25    = cmd_q[KEY_SEL25];
  assign sel5     = cmd_q[KEY_SEL5];
  assign pending  = pend_q;

endmodule

// File: tb/tb_seller_key_cond.sv
// tb_seller_key_cond: directed scenarios plus random
// bouncing keys against a run-length reference model.
module tb_seller_key_cond;
  import seller_pkg::*;

  localparam int N = 4;

  logic     cp = 1'b0;
  logic     rst = 1'b1;
  key_vec_t key_raw = '0;
  logic     start, rmb1, rmb10;
  logic     sel25, sel5, cancel_n;
  key_vec_t pending;

  seller_key_cond #(.DEBOUNCE_CYCLES(N)) dut (
    .cp       (cp),
    .rst      (rst),
    .key_raw  (key_raw),
    .start    (start),
    .rmb1     (rmb1),
    .rmb10    (rmb10),
    .sel25    (sel25),
    .sel5     (sel5),
    .cancel_n (cancel_n),
    .pending  (pending)
  );

  always #5 cp = ~cp;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: raw seen two edges late; a key's
  // level is accepted after N straight disagreeing
  // samples; queued presses served lowest index first.
  int       m_s1[NUM_KEYS];
  int       m_s2[NUM_KEYS];
  int       m_lvl[NUM_KEYS];
  int       m_run[NUM_KEYS];
  int       m_new[NUM_KEYS];
  key_vec_t m_pend;
  key_vec_t m_cmd;

  int edge_n;
  int pulses[NUM_KEYS];
  int first_edge[NUM_KEYS];
  int last_edge[NUM_KEYS];

  function automatic key_vec_t dut_cmd();
    key_vec_t v;
    v[KEY_CANCEL] = ~cancel_n;
    v[KEY_START]  = start;
    v[KEY_RMB10]  = rmb10;
    v[KEY_RMB1]   = rmb1;
    v[KEY_SEL25]  = sel25;
    v[KEY_SEL5]   = sel5;
    return v;
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t got=%0h exp=%0h",
               tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    key_vec_t waiting;
    int       old;
    int       won;
    if (rst) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0;
        m_run[k] = 0; m_new[k] = 0;
      end
      m_pend = '0;
      m_cmd  = '0;
      return;
    end
    waiting = m_pend;
    for (int k = 0; k < NUM_KEYS; k++)
      if (m_new[k] != 0) waiting[k] = 1'b1;
    won = -1;
    for (int k = NUM_KEYS-1; k >= 0; k--)
      if (waiting[k]) won = k;
    m_cmd = '0;
    if (won >= 0) begin
      m_cmd[won]   = 1'b1;
      waiting[won] = 1'b0;
    end
    m_pend = waiting;
    for (int k = 0; k < NUM_KEYS; k++) begin
      old = m_lvl[k];
      if (m_s2[k] != m_lvl[k]) m_run[k]++;
      else m_run[k] = 0;
      if (m_run[k] == N) begin
        m_lvl[k] = m_s2[k];
        m_run[k] = 0;
      end
      m_new[k] = (old == 0 && m_lvl[k] == 1) ? 1 : 0;
      m_s2[k] = m_s1[k];
      m_s1[k] = int'(key_raw[k]);
    end
  endtask

  task automatic tick();
    key_vec_t c;
    @(posedge cp);
    model_step();
    #1;
    edge_n++;
    c = dut_cmd();
    check("cmd", c, m_cmd);
    check("pending", pending, m_pend);
    check("onehot", $countones(c) <= 1, 1);
    for (int k = 0; k < NUM_KEYS; k++)
      if (c[k]) begin
        pulses[k]++;
        if (first_edge[k] == 0) first_edge[k] = edge_n;
        last_edge[k] = edge_n;
      end
  endtask

  task automatic scn_start();
    edge_n = 0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      pulses[k] = 0;
      first_edge[k] = 0;
      last_edge[k] = 0;
    end
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  int hold_left[NUM_KEYS];

  initial begin
    scn_start();
    rst = 1'b1;
    key_raw = '0;
    hold(2);
    rst = 1'b0;
    repeat (20) begin
      tick();
      check("idle_cancel_n", cancel_n, 1);
      check("idle_pending", pending, 0);
      check("idle_cmd", dut_cmd(), 0);
    end

    scn_start();
    key_raw[KEY_RMB1] = 1'b1;
    hold(30);
    key_raw[KEY_RMB1] = 1'b0;
    hold(12);
    check("rmb1_count", pulses[KEY_RMB1], 1);
    check("rmb1_edge", first_edge[KEY_RMB1], 7);

    scn_start();
    key_raw[KEY_RMB10] = 1'b1; hold(3);
    key_raw[KEY_RMB10] = 1'b0; hold(1);
    key_raw[KEY_RMB10] = 1'b1; hold(10);
    key_raw[KEY_RMB10] = 1'b0; hold(12);
    check("rmb10_count", pulses[KEY_RMB10], 1);
    check("rmb10_edge", first_edge[KEY_RMB10], 11);
    scn_start();
    key_raw[KEY_RMB10] = 1'b1; hold(3);
    key_raw[KEY_RMB10] = 1'b0; hold(12);
    check("glitch_count", pulses[KEY_RMB10], 0);

    scn_start();
    key_raw[KEY_CANCEL] = 1'b1;
    key_raw[KEY_SEL25]  = 1'b1;
    key_raw[KEY_SEL5]   = 1'b1;
    repeat (15) begin
      tick();
      if (edge_n == 7)
        check("pend_e7", pending, 6'b110000);
      if (edge_n == 8)
        check("pend_e8", pending, 6'b100000);
      if (edge_n == 9)
        check("pend_e9", pending, 6'b000000);
    end
    key_raw = '0;
    hold(12);
    check("cancel_edge", first_edge[KEY_CANCEL], 7);
    check("sel25_edge", first_edge[KEY_SEL25], 8);
    check("sel5_edge", first_edge[KEY_SEL5], 9);
    check("triple_count",
          pulses[KEY_CANCEL] + pulses[KEY_SEL25]
          + pulses[KEY_SEL5], 3);

    scn_start();
    key_raw[KEY_START] = 1'b1;
    hold(4);
    rst = 1'b1;
    hold(1);
    rst = 1'b0;
    hold(15);
    key_raw[KEY_START] = 1'b0;
    hold(12);
    check("start_count", pulses[KEY_START], 1);
    check("start_edge", first_edge[KEY_START], 12);

    scn_start();
    key_raw[KEY_SEL5] = 1'b1; hold(8);
    key_raw[KEY_SEL5] = 1'b0; hold(8);
    key_raw[KEY_SEL5] = 1'b1; hold(8);
    key_raw[KEY_SEL5] = 1'b0; hold(12);
    check("sel5_count", pulses[KEY_SEL5], 2);
    check("sel5_gap",
          last_edge[KEY_SEL5] - first_edge[KEY_SEL5], 16);

    for (int k = 0; k < NUM_KEYS; k++)
      hold_left[k] = $urandom_range(1, 12);
    repeat (4000) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        hold_left[k]--;
        if (hold_left[k] <= 0) begin
          key_raw[k] = ~key_raw[k];
          hold_left[k] = $urandom_range(1, 12);
        end
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    key_raw = '0;
    hold(12);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
